qubo_demon_sweeper: RTL
=======================

QUBO_DEMON_SWEEPER -- requirements
Module: qubo_demon_sweeper

Interface
REQ-001 SHALL take parameter NUM_SPINS, default 8, number of binary spins (power of two, 4..16).
REQ-002 SHALL take parameter WEIGHT_W, default 4, signed coupling width.
REQ-003 SHALL take parameter DEMON_W, default 8, unsigned demon energy width.
REQ-004 SHALL take parameter MAX_COUNT, default 1000, number of full sweeps per run.
REQ-005 SHALL have exactly one clock and a synchronous, active-high reset.
REQ-006 SHALL have port clk  in  1  sole clock, rising edge.
REQ-007 SHALL have port rst  in  1  synchronous active-high reset.
REQ-008 SHALL have port cfg_we  in  1  coupling write strobe.
REQ-009 SHALL have port cfg_addr  in  clog2(NUM_SPINS^2)  coupling index i*NUM_SPINS+j.
REQ-010 SHALL have port cfg_data  in  WEIGHT_W  signed J[i][j].
REQ-011 SHALL have port start  in  1  run request.
REQ-012 SHALL have port spin_init  in  NUM_SPINS  initial spins (bit 1 = +1, bit 0 = -1).
REQ-013 SHALL have port demon_init  in  DEMON_W  initial demon energy.
REQ-014 SHALL have port spins  out  NUM_SPINS  current spin state.
REQ-015 SHALL have port demon  out  DEMON_W  current demon energy.
REQ-016 SHALL have port sweep_count  out  clog2(MAX_COUNT+1)  completed sweeps.
REQ-017 SHALL have port busy  out  1  run in progress.
REQ-018 SHALL have port done  out  1  one-cycle end-of-run pulse.

Function
REQ-019 SHALL implement FSM states IDLE, ACCUM, DECIDE.
REQ-020 IDLE: cfg_we writes J[cfg_addr] at the edge; cfg_we outside IDLE SHALL be ignored; diagonal entries stored but never used.
REQ-021 IDLE with start=1 at edge t: load spins<=spin_init, demon<=demon_init, sweep_count<=0, i<=0, j<=0, acc<=0, busy<=1, go ACCUM; start outside IDLE ignored.
REQ-022 ACCUM: one j per cycle for NUM_SPINS cycles, acc += (j==i ? 0 : J[i][j]*s_j), s_j = +/-1; then go DECIDE.
REQ-023 acc SHALL be signed, width WEIGHT_W+clog2(NUM_SPINS)+1, never overflowing; dE = 2*s_i*acc, one bit wider.
REQ-024 DECIDE: if dE <= demon (signed compare, demon zero-extended) flip spin i and set demon <= demon - dE, saturating at 2^DEMON_W-1; else no change.
REQ-025 DECIDE: i increments; at i wrap to 0 sweep_count increments; next state ACCUM with j<=0, acc<=0.
REQ-026 After DECIDE of spin NUM_SPINS-1 in sweep MAX_COUNT: state IDLE, busy<=0, done<=1 for exactly one cycle.
REQ-027 Run latency: done high in the cycle after edge t+MAX_COUNT*NUM_SPINS*(NUM_SPINS+1); first spin decision visible after edge t+NUM_SPINS+1.
REQ-028 spins, demon, sweep_count SHALL hold their final values in IDLE until next start or reset.

Reset
REQ-029 rst=1 at an edge SHALL force IDLE, spins=0, demon=0, sweep_count=0, busy=0, done=0, all J=0, from any state including mid-run.
REQ-030 rst SHALL dominate start and cfg_we in the same cycle.

Configuration
REQ-031 With QUBO_DEMON_BIAS_EN defined: per-spin signed WEIGHT_W bias b_i written via cfg_addr = NUM_SPINS^2+i (address widened by one bit), added to acc in DECIDE; reset to 0.
REQ-032 Without QUBO_DEMON_BIAS_EN: no bias storage, address width as REQ-009, field is couplings only.

Structure
REQ-033 Shared package qubo_pkg SHALL hold the FSM state enum and the width helper functions for acc/dE.
REQ-034 Coupling storage SHALL be one sub-module qubo_coupling_ram (sync write, async read by {i,j}).

Verification (NUM_SPINS=8, WEIGHT_W=4, DEMON_W=8, MAX_COUNT=2)
REQ-035 Reset mid-ACCUM -> next cycle busy=0, spins=0x00, demon=0, sweep_count=0; done never pulses.
REQ-036 All J=0, spin_init=0x00, demon_init=0, start -> each dE=0 accepted, spins=0x00 at end, demon=0, done in cycle after edge t+144.
REQ-037 All off-diagonal J=+1, spin_init=0xFF, demon_init=10 -> every dE=14 rejected; end spins=0xFF, demon=10, sweep_count=2.
REQ-038 All off-diagonal J=+1, spin_init=0xFE, demon_init=250 -> after edge t+9 spins[0]=1, demon=255 (saturated).
REQ-039 cfg_we with cfg_data=7 while busy -> J unchanged, next run identical to REQ-037.
REQ-040 With QUBO_DEMON_BIAS_EN, all J=0, b_0=+3, spin_init=0x01, demon_init=5 -> dE(spin0)=6 rejected, spins[0] stays 1, demon=5 after edge t+9.

Source files
------------

// File: rtl/qubo_pkg.sv
// Shared FSM state type and datapath width helpers for the QUBO demon sweeper.
// QUBO_DEMON_BIAS_EN widens the configuration address by one bit for per-spin biases.
package qubo_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    DECIDE = 2'd2
  } state_t;

  function automatic int unsigned acc_width(input int unsigned weight_w, input int unsigned num_spins);
    return weight_w + $clog2(num_spins) + 1;
  endfunction

  function automatic int unsigned de_width(input int unsigned weight_w, input int unsigned num_spins);
    return acc_width(weight_w, num_spins) + 1;
  endfunction

  function automatic int unsigned cfg_addr_width(input int unsigned num_spins);
`ifdef QUBO_DEMON_BIAS_EN
    return $clog2(num_spins * num_spins) + 1;
`else
    return $clog2(num_spins * num_spins);
`endif
  endfunction

endpackage

// File: rtl/qubo_coupling_ram.sv
// Coupling matrix J[i][j]: synchronous write, asynchronous read addressed by {i,j}.
module qubo_coupling_ram #(
  parameter int unsigned NUM_SPINS = 8,
  parameter int unsigned WEIGHT_W  = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               we,
  input  logic [2*$clog2(NUM_SPINS)-1:0]     waddr,
  input  logic [WEIGHT_W-1:0]                wdata,
  input  logic [$clog2(NUM_SPINS)-1:0]       raddr_i,
  input  logic [$clog2(NUM_SPINS)-1:0]       raddr_j,
  output logic [WEIGHT_W-1:0]                rdata_c
);

  localparam int unsigned DEPTH = NUM_SPINS * NUM_SPINS;

  logic [WEIGHT_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      mem <= '{default: '0};
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_c = mem[{raddr_i, raddr_j}];

endmodule

// File: rtl/qubo_demon_sweeper.sv
// Demon-algorithm QUBO sweeper: sequential local-field accumulation and microcanonical spin flips.
// Optional per-spin bias terms enabled by QUBO_DEMON_BIAS_EN.
module qubo_demon_sweeper
  import qubo_pkg::*;
#(
  parameter int unsigned NUM_SPINS = 8,
  parameter int unsigned WEIGHT_W  = 4,
  parameter int unsigned DEMON_W   = 8,
  parameter int unsigned MAX_COUNT = 1000
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 cfg_we,
  input  logic [cfg_addr_width(NUM_SPINS)-1:0] cfg_addr,
  input  logic [WEIGHT_W-1:0]                  cfg_data,
  input  logic                                 start,
  input  logic [NUM_SPINS-1:0]                 spin_init,
  input  logic [DEMON_W-1:0]                   demon_init,
  output logic [NUM_SPINS-1:0]                 spins,
  output logic [DEMON_W-1:0]                   demon,
  output logic [$clog2(MAX_COUNT+1)-1:0]       sweep_count,
  output logic                                 busy,
  output logic                                 done
);

  localparam int unsigned IW    = $clog2(NUM_SPINS);
  localparam int unsigned AW    = cfg_addr_width(NUM_SPINS);
  localparam int unsigned ACC_W = acc_width(WEIGHT_W, NUM_SPINS);
  localparam int unsigned DE_W  = de_width(WEIGHT_W, NUM_SPINS);
  localparam int unsigned SC_W  = $clog2(MAX_COUNT + 1);
  localparam int unsigned CMP_W = ((DE_W > DEMON_W + 1) ? DE_W : DEMON_W + 1) + 1;

  state_t state, state_nxt;

  logic [IW-1:0]              i_idx, j_idx;
  logic signed [ACC_W-1:0]    acc, acc_term_c, acc_sum_c;
  logic [WEIGHT_W-1:0]        rdata_c;
  logic signed [WEIGHT_W-1:0] j_weight_c;
  logic signed [DE_W-1:0]     de_c;
  logic signed [CMP_W-1:0]    de_ext_c, demon_ext_c, demon_diff_c;
  logic [DEMON_W-1:0]         demon_nxt_c;
  logic                       accept_c, last_c, ram_we_c;

`ifdef QUBO_DEMON_BIAS_EN
  logic signed [WEIGHT_W-1:0] bias [NUM_SPINS];
  assign ram_we_c = cfg_we && (state == IDLE) && !cfg_addr[AW-1];

  // Bias window sits directly above the coupling field.
  always_ff @(posedge clk) begin
    if (rst) begin
      bias <= '{default: '0};
    end else if (cfg_we && (state == IDLE) && cfg_addr[AW-1] && (cfg_addr[AW-2:IW] == '0)) begin
      bias[cfg_addr[IW-1:0]] <= cfg_data;
    end
  end
`else
  assign ram_we_c = cfg_we && (state == IDLE);
`endif

  qubo_coupling_ram #(
    .NUM_SPINS (NUM_SPINS),
    .WEIGHT_W  (WEIGHT_W)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .we      (ram_we_c),
    .waddr   (cfg_addr[2*IW-1:0]),
    .wdata   (cfg_data),
    .raddr_i (i_idx),
    .raddr_j (j_idx),
    .rdata_c (rdata_c)
  );

  // Local field term, energy change and demon update.
  always_comb begin
    j_weight_c = rdata_c;
    acc_term_c = '0;
    if (j_idx != i_idx) begin
      acc_term_c = spins[j_idx] ? ACC_W'(j_weight_c) : -ACC_W'(j_weight_c);
    end
`ifdef QUBO_DEMON_BIAS_EN
    acc_sum_c = acc + ACC_W'(bias[i_idx]);
`else
    acc_sum_c = acc;
`endif
    de_c = {acc_sum_c, 1'b0};
    if (!spins[i_idx]) begin
      de_c = -de_c;
    end
    de_ext_c     = CMP_W'(de_c);
    demon_ext_c  = CMP_W'(demon);
    accept_c     = (de_ext_c <= demon_ext_c);
    demon_diff_c = demon_ext_c - de_ext_c;
    demon_nxt_c  = (|demon_diff_c[CMP_W-1:DEMON_W]) ? '1 : demon_diff_c[DEMON_W-1:0];
    last_c       = (i_idx == IW'(NUM_SPINS - 1)) && (sweep_count == SC_W'(MAX_COUNT - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ACCUM;
      ACCUM:   if (j_idx == IW'(NUM_SPINS - 1)) state_nxt = DECIDE;
      DECIDE:  state_nxt = last_c ? IDLE : ACCUM;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      spins       <= '0;
      demon       <= '0;
      sweep_count <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      i_idx       <= '0;
      j_idx       <= '0;
      acc         <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            spins       <= spin_init;
            demon       <= demon_init;
            sweep_count <= '0;
            i_idx       <= '0;
            j_idx       <= '0;
            acc         <= '0;
            busy        <= 1'b1;
          end
        end
        ACCUM: begin
          acc   <= acc + acc_term_c;
          j_idx <= j_idx + 1'b1;
        end
        DECIDE: begin
          if (accept_c) begin
            spins[i_idx] <= ~spins[i_idx];
            demon        <= demon_nxt_c;
          end
          i_idx <= i_idx + 1'b1;
          j_idx <= '0;
          acc   <= '0;
          if (i_idx == IW'(NUM_SPINS - 1)) begin
            sweep_count <= sweep_count + 1'b1;
          end
          if (last_c) begin
            busy <= 1'b0;
            done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
